// File: rtl/noc_pkg.sv
// Shared flit layout, the single-flit type code and the TX state encoding for the
// NoC network-interface slice.
package noc_pkg;

    localparam int FLIT_W   = 40;
    localparam int SRC_MSB  = 39;
    localparam int SRC_LSB  = 36;
    localparam int DST_MSB  = 35;
    localparam int DST_LSB  = 32;
    localparam int TS_MSB   = 31;
    localparam int TS_LSB   = 24;
    localparam int DATA_MSB = 23;
    localparam int DATA_LSB = 2;
    localparam int TYPE_MSB = 1;
    localparam int TYPE_LSB = 0;

    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_HOLD = 2'd2
    } tx_state_t;

    function automatic logic [FLIT_W-1:0] make_flit(input logic [3:0]  src,
                                                    input logic [3:0]  dst,
                                                    input logic [7:0]  ts,
                                                    input logic [21:0] data);
        return {src, dst, ts, data, TYPE_SINGLE};
    endfunction

endpackage

// File: rtl/ni_local_port_if.sv
// PE injection handshake between a processing element (master) and its network
// interface (slave).
interface ni_local_port_if;

    logic        pe_valid;
    logic        pe_ready;
    logic [3:0]  pe_dst;
    logic [21:0] pe_data;

    modport master (output pe_valid, output pe_dst, output pe_data, input pe_ready);
    modport slave  (input pe_valid, input pe_dst, input pe_data, output pe_ready);

endinterface

// File: rtl/ni_tx_fifo.sv
// DEPTH x WIDTH circular buffer holding flits waiting for the router local input.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ni_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately left out of reset; clearing the pointers
    // already makes every stale entry unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ni_local_port.sv
// Network interface for a router local port: stamps and queues PE flits, receives
// and checks delivered flits. Define NI_LATENCY_STAT_EN to add latency statistics.
module ni_local_port
    import noc_pkg::*;
#(
    parameter logic [3:0] NODE_ID  = 4'd0,
    parameter int         DATASIZE = 40,
    parameter int         DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ni_local_port_if.slave      pe,
    output logic [DATASIZE-1:0] L_data_out,
    output logic                L_valid_out,
    input  logic                L_full_in,
    input  logic [DATASIZE-1:0] L_data_in,
    input  logic                L_valid_in,
    output logic                rx_valid,
    output logic [3:0]          rx_src,
    output logic [21:0]         rx_data,
    output logic [7:0]          rx_latency,
    output logic [15:0]         tx_cnt,
    output logic [15:0]         rx_cnt,
    output logic                err_misroute
`ifdef NI_LATENCY_STAT_EN
    ,
    output logic [7:0]          lat_max,
    output logic [23:0]         lat_sum
`endif
);

    logic [7:0]          now;
    logic                q_full;
    logic                q_empty;
    logic                q_push;
    logic                q_pop;
    logic [DATASIZE-1:0] q_head;
    logic [DATASIZE-1:0] tx_flit;
    tx_state_t           state;
    tx_state_t           next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) now <= '0;
        else        now <= now + 8'd1;
    end

    assign pe.pe_ready = !q_full;
    assign q_push      = pe.pe_valid && !q_full;
    assign tx_flit     = DATASIZE'(make_flit(NODE_ID, pe.pe_dst, now, pe.pe_data));

    ni_tx_fifo #(.DEPTH(DEPTH), .WIDTH(DATASIZE)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (q_push),
        .wr_data (tx_flit),
        .pop     (q_pop),
        .rd_data (q_head),
        .full    (q_full),
        .empty   (q_empty)
    );

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            TX_IDLE: if (!q_empty) next_state = L_full_in ? TX_HOLD : TX_SEND;
            TX_SEND: begin
                if (q_empty)        next_state = TX_IDLE;
                else if (L_full_in) next_state = TX_HOLD;
            end
            TX_HOLD: if (!L_full_in) next_state = TX_SEND;
            default: next_state = TX_IDLE;
        endcase
    end

    // Entering SEND is where the head is captured and popped, so the SEND cycle
    // presents that flit while the FSM already looks at the remaining entries.
    assign q_pop       = (next_state == TX_SEND);
    assign L_valid_out = (state == TX_SEND);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= TX_IDLE;
            L_data_out <= '0;
            tx_cnt     <= '0;
        end else begin
            state <= next_state;
            if (q_pop) begin
                L_data_out <= q_head;
                if (tx_cnt != 16'hFFFF) tx_cnt <= tx_cnt + 16'd1;
            end
        end
    end

    logic       rx_hit;
    logic       rx_miss;
    logic [7:0] rx_lat;
    logic [1:0] unused_type;

    assign rx_hit      = L_valid_in && (L_data_in[DST_MSB:DST_LSB] == NODE_ID);
    assign rx_miss     = L_valid_in && (L_data_in[DST_MSB:DST_LSB] != NODE_ID);
    assign rx_lat      = now - L_data_in[TS_MSB:TS_LSB];
    assign unused_type = L_data_in[TYPE_MSB:TYPE_LSB];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid     <= 1'b0;
            rx_src       <= '0;
            rx_data      <= '0;
            rx_latency   <= '0;
            rx_cnt       <= '0;
            err_misroute <= 1'b0;
        end else begin
            rx_valid <= rx_hit;
            if (rx_hit) begin
                rx_src     <= L_data_in[SRC_MSB:SRC_LSB];
                rx_data    <= L_data_in[DATA_MSB:DATA_LSB];
                rx_latency <= rx_lat;
                if (rx_cnt != 16'hFFFF) rx_cnt <= rx_cnt + 16'd1;
            end
            if (rx_miss) err_misroute <= 1'b1;
        end
    end

`ifdef NI_LATENCY_STAT_EN
    logic [24:0] lat_sum_wide;
    assign lat_sum_wide = {1'b0, lat_sum} + {17'd0, rx_lat};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_max <= '0;
            lat_sum <= '0;
        end else if (rx_hit) begin
            if (rx_lat > lat_max) lat_max <= rx_lat;
            lat_sum <= lat_sum_wide[24] ? 24'hFFFFFF : lat_sum_wide[23:0];
        end
    end
`endif

endmodule

// File: tb/tb_ni_local_port.sv
// Self-checking bench for ni_local_port: scoreboards for outgoing flits and
// delivered packets plus directed checks of reset, backpressure and misrouting.
module tb_ni_local_port;

    localparam logic [3:0] NID = 4'h2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [39:0] L_data_out;
    logic        L_valid_out;
    logic        L_full_in;
    logic [39:0] L_data_in;
    logic        L_valid_in;
    logic        rx_valid;
    logic [3:0]  rx_src;
    logic [21:0] rx_data;
    logic [7:0]  rx_latency;
    logic [15:0] tx_cnt;
    logic [15:0] rx_cnt;
    logic        err_misroute;
`ifdef NI_LATENCY_STAT_EN
    logic [7:0]  lat_max;
    logic [23:0] lat_sum;
`endif

    ni_local_port_if pe_if ();

    ni_local_port #(.NODE_ID(NID), .DATASIZE(40), .DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pe           (pe_if),
        .L_data_out   (L_data_out),
        .L_valid_out  (L_valid_out),
        .L_full_in    (L_full_in),
        .L_data_in    (L_data_in),
        .L_valid_in   (L_valid_in),
        .rx_valid     (rx_valid),
        .rx_src       (rx_src),
        .rx_data      (rx_data),
        .rx_latency   (rx_latency),
        .tx_cnt       (tx_cnt),
        .rx_cnt       (rx_cnt),
        .err_misroute (err_misroute)
`ifdef NI_LATENCY_STAT_EN
        ,
        .lat_max      (lat_max),
        .lat_sum      (lat_sum)
`endif
    );

    always #5 clk = ~clk;

    // Reference cycle counter: cleared by reset, advancing on every rising edge.
    logic [7:0] m_now;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_now <= 8'd0;
        else        m_now <= m_now + 8'd1;
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_tx_seen = 0;
    int          exp_tx_cnt = 0;
    int          exp_rx_cnt = 0;
    logic [39:0] tx_q [$];
    logic [33:0] rx_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: log an accepted PE push, step to the next falling edge, then
    // score whatever the DUT presents.
    task automatic tick();
        if (pe_if.pe_valid && pe_if.pe_ready) begin
            tx_q.push_back({NID, pe_if.pe_dst, m_now, pe_if.pe_data, 2'b11});
            exp_tx_cnt++;
        end
        @(posedge clk);
        @(negedge clk);
        if (L_valid_out) begin
            n_tx_seen++;
            if (tx_q.size() == 0) check("tx_unexpected", 64'(L_valid_out), 64'(0));
            else                  check("tx_flit", 64'(L_data_out), 64'(tx_q.pop_front()));
        end
        if (rx_valid) begin
            if (rx_q.size() == 0) check("rx_unexpected", 64'(rx_valid), 64'(0));
            else check("rx_pkt", 64'({rx_src, rx_data, rx_latency}), 64'(rx_q.pop_front()));
        end
    endtask

    task automatic send_rx(input logic [3:0] src, input logic [3:0] dst,
                           input logic [7:0] ts, input logic [21:0] data);
        L_valid_in = 1'b1;
        L_data_in  = {src, dst, ts, data, 2'b11};
        if (dst == NID) begin
            rx_q.push_back({src, data, 8'(m_now - ts)});
            exp_rx_cnt++;
        end
        tick();
        L_valid_in = 1'b0;
    endtask

    task automatic wait_now(input logic [7:0] target);
        for (int i = 0; i < 300; i++) begin
            if (m_now == target) break;
            tick();
        end
        check("wait_now", 64'(m_now), 64'(target));
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"}, 64'(pe_if.pe_ready), 64'(1));
        check({tag, "_tx"}, 64'({L_valid_out, L_data_out}), 64'(0));
        check({tag, "_rx"}, 64'({rx_valid, rx_src, rx_data, rx_latency}), 64'(0));
        check({tag, "_stat"}, 64'({tx_cnt, rx_cnt, err_misroute}), 64'(0));
`ifdef NI_LATENCY_STAT_EN
        check({tag, "_lat"}, 64'({lat_max, lat_sum}), 64'(0));
`endif
    endtask

    initial begin
        int          seen;
        logic [39:0] flit29;

        pe_if.pe_valid = 1'b0;
        pe_if.pe_dst   = '0;
        pe_if.pe_data  = '0;
        L_full_in      = 1'b0;
        L_valid_in     = 1'b0;
        L_data_in      = '0;

        #2 rst_n = 1'b0;
        #10 reset_checks("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // Single injection stamped at now=7, appearing one cycle after acceptance.
        wait_now(8'd7);
        pe_if.pe_valid = 1'b1;
        pe_if.pe_dst   = 4'h5;
        pe_if.pe_data  = 22'h1ABCD;
        tick();
        pe_if.pe_valid = 1'b0;
        check("accept_no_tx_yet", 64'(L_valid_out), 64'(0));
        tick();
        flit29 = {4'h2, 4'h5, 8'h07, 22'h1ABCD, 2'b11};
        check("first_valid", 64'(L_valid_out), 64'(1));
        check("first_flit", 64'(L_data_out), 64'(flit29));
        check("first_tx_cnt", 64'(tx_cnt), 64'(1));
        tick();
        check("single_cycle", 64'(L_valid_out), 64'(0));
        check("data_held", 64'(L_data_out), 64'(flit29));

        // Backpressure: fill the queue under L_full_in, then drain back to back.
        L_full_in = 1'b1;
        seen = n_tx_seen;
        for (int i = 0; i < 4; i++) begin
            pe_if.pe_valid = 1'b1;
            pe_if.pe_dst   = 4'(i + 1);
            pe_if.pe_data  = 22'(32'h100 + i);
            check("fill_ready", 64'(pe_if.pe_ready), 64'(1));
            tick();
        end
        pe_if.pe_dst  = 4'hF;
        pe_if.pe_data = 22'h3FFFF;
        check("full_ready", 64'(pe_if.pe_ready), 64'(0));
        tick();
        check("hold_no_tx", 64'(n_tx_seen - seen), 64'(0));
        L_full_in = 1'b0;
        check("pushpop_ready", 64'(pe_if.pe_ready), 64'(0));
        tick();
        pe_if.pe_valid = 1'b0;
        check("drain_first", 64'(L_valid_out), 64'(1));
        repeat (3) tick();
        check("drain_b2b", 64'(n_tx_seen - seen), 64'(4));
        tick();
        check("drain_idle", 64'(L_valid_out), 64'(0));

        // Receive with timestamp wrap: ts=250 at now=4 gives latency 10.
        wait_now(8'd4);
        send_rx(4'h9, NID, 8'd250, 22'h2AAAA);
        check("rx_lat_wrap", 64'(rx_latency), 64'(10));
        check("rx_cnt_1", 64'(rx_cnt), 64'(1));
        tick();
        check("rx_pulse", 64'(rx_valid), 64'(0));

        // TX pop and RX delivery in the same cycle.
        pe_if.pe_valid = 1'b1;
        pe_if.pe_dst   = 4'h3;
        pe_if.pe_data  = 22'h0BEEF;
        tick();
        pe_if.pe_valid = 1'b0;
        send_rx(4'h4, NID, m_now - 8'd6, 22'h12345);
        check("simul_tx_rx", 64'({L_valid_out, rx_valid}), 64'(2'b11));
        tick();
        check("tx_cnt_total", 64'(tx_cnt), 64'(exp_tx_cnt));
        check("rx_cnt_total", 64'(rx_cnt), 64'(exp_rx_cnt));

        // Misrouted flit: no delivery, sticky error.
        send_rx(4'h1, 4'h7, m_now, 22'h00001);
        check("misroute_no_rx", 64'(rx_valid), 64'(0));
        check("misroute_err", 64'(err_misroute), 64'(1));
        repeat (3) tick();
        check("misroute_sticky", 64'(err_misroute), 64'(1));
        check("misroute_rx_cnt", 64'(rx_cnt), 64'(exp_rx_cnt));

        // Asynchronous reset while three flits wait in HOLD.
        L_full_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pe_if.pe_valid = 1'b1;
            pe_if.pe_dst   = 4'(8 + i);
            pe_if.pe_data  = 22'(32'h3000 + i);
            tick();
        end
        pe_if.pe_valid = 1'b0;
        repeat (2) tick();
        check("pre_rst_data", 64'(L_data_out != 40'd0), 64'(1));
        #2 rst_n = 1'b0;
        #1 reset_checks("rst_mid");
        tx_q.delete();
        exp_tx_cnt = 0;
        exp_rx_cnt = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        L_full_in = 1'b0;
        seen = n_tx_seen;
        repeat (6) tick();
        check("no_ghost_flits", 64'(n_tx_seen - seen), 64'(0));

        // Latency series 3, 9, 5.
        send_rx(4'hA, NID, m_now - 8'd3, 22'h00A01);
        send_rx(4'hA, NID, m_now - 8'd9, 22'h00A02);
        send_rx(4'hA, NID, m_now - 8'd5, 22'h00A03);
        tick();
        check("rx_cnt_series", 64'(rx_cnt), 64'(3));
`ifdef NI_LATENCY_STAT_EN
        check("lat_max", 64'(lat_max), 64'(9));
        check("lat_sum", 64'(lat_sum), 64'(17));
`endif

        check("tx_sb_drain", 64'(tx_q.size()), 64'(0));
        check("rx_sb_drain", 64'(rx_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ni_local_port.md
NI_LOCAL_PORT -- requirements
Module: ni_local_port

Interface
REQ-001 SHALL have parameter NODE_ID, default 0: 4-bit node address stamped into src and checked against dst.
REQ-002 SHALL have parameter DATASIZE, default 40: flit width.
REQ-003 SHALL have parameter DEPTH, default 4: TX queue entries, power of two.
REQ-004 SHALL have port clk, input, 1: single clock. Everything is rising-edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports pe_valid (input, 1), pe_ready (output, 1), pe_dst (input, 4) and pe_data (input, 22): PE injection handshake.
REQ-007 SHALL have ports L_data_out (output, DATASIZE) and L_valid_out (output, 1): flit to the router local input.
REQ-008 SHALL have port L_full_in, input, 1: router local input FIFO full.
REQ-009 SHALL have ports L_data_in (input, DATASIZE) and L_valid_in (input, 1): flit from the router local output.
REQ-010 SHALL have ports rx_valid (output, 1), rx_src (output, 4), rx_data (output, 22) and rx_latency (output, 8): delivered packet to the PE.
REQ-011 SHALL have ports tx_cnt and rx_cnt (outputs, 16 each) and err_misroute (output, 1): status.

Function
REQ-012 Flit layout SHALL be src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0]. This NI generates type 2'b11 (single-flit) only.
REQ-013 An 8-bit free-running counter now SHALL increment every cycle and wrap 255->0.
REQ-014 pe_ready SHALL equal NOT queue_full, combinationally.
- On pe_valid&&pe_ready, the flit {NODE_ID, pe_dst, now, pe_data, 2'b11} is written to the TX queue tail.
REQ-015 TX FSM states:
- IDLE (queue empty).
- SEND: L_valid_out=1 with the head flit for exactly one cycle, then pop.
- HOLD: queue non-empty and L_full_in=1.
REQ-016 Transitions SHALL evaluate on the registered state.
- IDLE->SEND when queue non-empty and !L_full_in.
- IDLE->HOLD when queue non-empty and L_full_in.
- HOLD->SEND when !L_full_in.
- SEND->SEND if more entries and !L_full_in.
- Otherwise SEND goes to HOLD or IDLE.
REQ-017 Minimum latency SHALL be 1 cycle: a flit accepted at edge N appears on L_valid_out in cycle N+1 if L_full_in=0.
- Back-to-back throughput SHALL be one flit per cycle.
REQ-018 Push and pop in the same cycle on a full queue SHALL be legal; pe_ready still reflects pre-pop full, so the push is not accepted.
REQ-019 L_data_out SHALL hold its last value when L_valid_out=0.
REQ-020 On L_valid_in with dst==NODE_ID, the NI SHALL register for one cycle:
- rx_valid=1
- rx_src=src
- rx_data=data
- rx_latency=(now - timestamp) mod 256
REQ-021 On L_valid_in with dst!=NODE_ID, rx_valid SHALL stay 0 and err_misroute SHALL set sticky until reset.
REQ-022 tx_cnt SHALL increment on each SEND cycle. rx_cnt SHALL increment on each accepted rx. Both saturate at 16'hFFFF.
REQ-023 A simultaneous TX pop and RX receive SHALL both be processed in the same cycle.

Reset
REQ-024 Asserting rst_n low SHALL immediately set:
- state=IDLE, queue empty (pe_ready=1), now=0
- L_valid_out=0, L_data_out=0
- rx_valid=0, rx_src=0, rx_data=0, rx_latency=0
- tx_cnt=0, rx_cnt=0, err_misroute=0
REQ-025 Reset mid-transfer SHALL discard all queued flits without emitting them.

Configuration
REQ-026 Macro NI_LATENCY_STAT_EN SHALL, when defined, add outputs lat_max (8) and lat_sum (24).
- lat_max updates on each rx to max(lat_max, rx_latency).
- lat_sum accumulates rx_latency and saturates at all-ones.
- Both reset to 0.
- When undefined, neither port nor logic exists.

Structure
REQ-027 Package noc_pkg SHALL hold the field offsets/widths (SRC_MSB..TYPE_LSB), the TYPE_SINGLE=2'b11 constant and the tx_state_t enum.
REQ-028 The TX queue SHALL be sub-module ni_tx_fifo, a DEPTH x DATASIZE circular buffer with wrap pointers and full/empty flags.

Verification
REQ-029 Reset, then push dst=5, data=22'h1ABCD at now=7 with NODE_ID=2 -> next cycle L_valid_out=1 and L_data_out={4'h2,4'h5,8'h07,22'h1ABCD,2'b11}; tx_cnt=1.
REQ-030 Hold L_full_in=1 and push 5 flits, DEPTH=4 -> pe_ready=0 after 4 pushes with no L_valid_out. Release full -> 4 flits in FIFO order, one per cycle.
REQ-031 Inject an rx flit with dst=NODE_ID, timestamp=250, at now=4 -> rx_valid pulse with rx_latency=10 (wrap case); rx_cnt=1.
REQ-032 Inject an rx flit with dst!=NODE_ID -> rx_valid stays 0, err_misroute=1 and stays 1 until reset.
REQ-033 Pull rst_n low while 3 flits are queued and in HOLD -> all outputs return to reset values asynchronously, and no queued flit appears after release.
REQ-034 With NI_LATENCY_STAT_EN defined, receive latencies 3, 9, 5 -> lat_max=9 and lat_sum=17.
